// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: decode-stage interlock for a 5-stage pipeline.
// Compares D-stage Tuse against E/M-stage Tnew for register hazards and
// tracks a multi-cycle mult/div unit so MD instructions wait in decode.
// Also keeps a saturating count of stalled cycles.
module hazard_stall_unit #(
  parameter int TW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    D_rs_addr,
  input  logic [4:0]    D_rt_addr,
  input  logic [TW-1:0] D_tuse_rs,
  input  logic [TW-1:0] D_tuse_rt,
  input  logic          D_md,
  input  logic [4:0]    E_wr_addr,
  input  logic [TW-1:0] E_tnew,
  input  logic [4:0]    M_wr_addr,
  input  logic [TW-1:0] M_tnew,
  input  logic          E_md_start,
  input  logic          E_md_div,
  output logic          stall,
  output logic          D_en,
  output logic          E_flush,
  output logic          md_busy,
  output logic [31:0]   stall_cnt
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  md_state_t        md_state_q, md_state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic rs_stall;
  logic rt_stall;
  logic md_stall;

  // Register hazards: a consumer stalls when it needs the value sooner than
  // the producing stage can deliver it. Register 0 never carries a hazard.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    if (D_rs_addr != 5'd0) begin
      if ((D_rs_addr == E_wr_addr) && (D_tuse_rs < E_tnew)) rs_stall = 1'b1;
      if ((D_rs_addr == M_wr_addr) && (D_tuse_rs < M_tnew)) rs_stall = 1'b1;
    end
    if (D_rt_addr != 5'd0) begin
      if ((D_rt_addr == E_wr_addr) && (D_tuse_rt < E_tnew)) rt_stall = 1'b1;
      if ((D_rt_addr == M_wr_addr) && (D_tuse_rt < M_tnew)) rt_stall = 1'b1;
    end
  end

  // MD instructions wait while the unit is starting or still counting down.
  always_comb begin
    md_busy  = (md_cnt_q != '0);
    md_stall = D_md & (E_md_start | md_busy);
    stall    = rs_stall | rt_stall | md_stall;
    D_en     = ~stall;
    E_flush  = stall;
  end

  // MD next-state: load latency on a start from IDLE, count down while BUSY.
  // A zero latency loads 0 and stays IDLE, so md_busy never rises.
  // Starts arriving while BUSY are ignored.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (E_md_start) begin
          md_cnt_d   = E_md_div ? DIV_LOAD : MULT_LOAD;
          md_state_d = (md_cnt_d != '0) ? MD_BUSY : MD_IDLE;
        end
      end
      MD_BUSY: begin
        md_cnt_d   = md_cnt_q - 1'b1;
        md_state_d = (md_cnt_q == CNT_W'(1)) ? MD_IDLE : MD_BUSY;
      end
      default: begin
        md_state_d = MD_IDLE;
        md_cnt_d   = '0;
      end
    endcase
  end

  // Stalled-cycle counter saturates at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers; reset clears the MD count and performance counter at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state_q  <= MD_IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_state_q  <= md_state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: register hazards, MD busy timing,
// async reset mid-divide and stall counter saturation.
module tb_hazard_stall_unit;

  localparam int TW = 3;

  logic          clk;
  logic          reset;
  logic [4:0]    D_rs_addr, D_rt_addr, E_wr_addr, M_wr_addr;
  logic [TW-1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic          D_md, E_md_start, E_md_div;
  logic          stall, D_en, E_flush, md_busy;
  logic [31:0]   stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_stall_unit #(
    .TW(TW), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md(D_md),
    .E_wr_addr(E_wr_addr), .E_tnew(E_tnew),
    .M_wr_addr(M_wr_addr), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .stall(stall), .D_en(D_en), .E_flush(E_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0;
    D_tuse_rs = '1;   D_tuse_rt = '1;
    D_md = 1'b0;
    E_wr_addr = 5'd0; E_tnew = '0;
    M_wr_addr = 5'd0; M_tnew = '0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset state
    #2;
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Load-use from E
    @(negedge clk);
    E_wr_addr = 5'd8; E_tnew = 3'd2; D_rs_addr = 5'd8; D_tuse_rs = 3'd1;
    #1;
    chk("lu_e_stall", {31'd0, stall}, 32'd1);
    chk("lu_e_d_en", {31'd0, D_en}, 32'd0);
    chk("lu_e_flush", {31'd0, E_flush}, 32'd1);
    clear_inputs();

    // Load in M, consumer needs it now
    @(negedge clk);
    M_wr_addr = 5'd8; M_tnew = 3'd1; D_rs_addr = 5'd8; D_tuse_rs = 3'd0;
    #1; chk("lu_m_tnew1", {31'd0, stall}, 32'd1);
    M_tnew = 3'd0;
    #1; chk("lu_m_tnew0", {31'd0, stall}, 32'd0);
    M_tnew = 3'd1; D_tuse_rs = 3'd1;
    #1; chk("lu_m_equal", {31'd0, stall}, 32'd0);
    clear_inputs();

    // Branch on ALU result via rt
    @(negedge clk);
    E_wr_addr = 5'd9; E_tnew = 3'd1; D_rt_addr = 5'd9; D_tuse_rt = 3'd0;
    #1; chk("br_rt_stall", {31'd0, stall}, 32'd1);
    E_wr_addr = 5'd0; D_rt_addr = 5'd0;
    #1; chk("br_r0_both", {31'd0, stall}, 32'd0);
    D_rt_addr = 5'd9;
    #1; chk("br_r0_dest", {31'd0, stall}, 32'd0);
    E_wr_addr = 5'd9; E_tnew = 3'd7; D_tuse_rt = 3'd7;
    #1; chk("never_used", {31'd0, stall}, 32'd0);
    clear_inputs();
    D_md = 1'b1;
    #1; chk("md_idle", {31'd0, stall}, 32'd0);
    clear_inputs();

    @(negedge clk);
    chk("cnt_after_comb", stall_cnt, 32'd0);

    // mult followed by mflo
    E_md_start = 1'b1; E_md_div = 1'b0; D_md = 1'b1;
    #1;
    chk("mult_start_stall", {31'd0, stall}, 32'd1);
    chk("mult_start_busy", {31'd0, md_busy}, 32'd0);
    @(posedge clk); #1;
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mult_busy_%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mult_stall_%0d", i), {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
    end
    chk("mult_done_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_done_stall", {31'd0, stall}, 32'd0);
    chk("mult_stall_cnt", stall_cnt, 32'd6);

    // div with a non-MD instruction in decode
    D_md = 1'b0; E_md_start = 1'b1; E_md_div = 1'b1;
    #1; chk("div_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    E_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("div_busy_%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div_stall_%0d", i), {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end
    chk("div_done_busy", {31'd0, md_busy}, 32'd0);
    chk("div_stall_cnt", stall_cnt, 32'd6);

    // Async reset in the middle of a divide
    E_md_start = 1'b1; E_md_div = 1'b1;
    @(posedge clk); #1;
    E_md_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("div2_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, md_busy}, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk); reset = 1'b0;
    D_md = 1'b1;
    #1; chk("post_rst_md_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("post_rst_cnt", stall_cnt, 32'd0);
    clear_inputs();

    // Saturation of the stalled-cycle counter
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("sat_preset", stall_cnt, 32'hFFFF_FFFD);
    E_wr_addr = 5'd8; E_tnew = 3'd2; D_rs_addr = 5'd8; D_tuse_rs = 3'd1;
    @(posedge clk); #1; chk("sat_inc1", stall_cnt, 32'hFFFF_FFFE);
    @(posedge clk); #1; chk("sat_inc2", stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1; chk("sat_hold1", stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1; chk("sat_hold2", stall_cnt, 32'hFFFF_FFFF);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
